// File: rtl/memory_interface_responder.sv
// Memory-interface responder: accepts one read/write request at a time,
// waits LATENCY cycles, then completes it with a one-cycle done pulse,
// registered read data and an out-of-range error flag, backed by a
// word-organised on-chip memory with byte-lane write enables.
//
// Handshake: memory_interface_enable is the request valid. The responder is
// ready only in IDLE (memory_interface_busy = 0); a request is taken on any
// rising edge where IDLE sees enable = 1. No back-pressure beyond busy: a
// requester that keeps enable high after done issues the same request again.
module memory_interface_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_interface_enable,
  input  logic        memory_interface_memory_state,
  input  logic [31:0] memory_interface_address,
  input  logic [3:0]  memory_interface_frame_mask,
  input  logic [31:0] memory_interface_write_data,
  output logic [31:0] memory_interface_read_data,
  output logic        memory_interface_done,
  output logic        memory_interface_busy,
  output logic        memory_interface_error,
  output logic [1:0]  dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  // Counter reload: WAIT lasts LATENCY cycles (LATENCY-1 down to 0).
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_write_q, req_write_d;
  logic [31:2] req_addr_q, req_addr_d;
  logic [3:0]  req_mask_q, req_mask_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH];

  // The byte offset never matters: lanes are selected by frame_mask.
  logic unused_addr_bits;
  assign unused_addr_bits = ^memory_interface_address[1:0];

  // Access being looked up this cycle. With LATENCY = 0 the read happens on
  // the acceptance edge itself, before the request registers hold anything,
  // so IDLE looks at the live inputs and WAIT looks at the captured request.
  logic [31:2]           acc_addr;
  logic [3:0]            acc_mask;
  logic                  acc_write;
  logic [DEPTH_LOG2-1:0] acc_index;
  logic                  acc_oor;
  logic [31:0]           rd_word;
  logic [31:0]           rd_lookup;

  assign acc_addr  = (state_q == S_IDLE) ? memory_interface_address[31:2] : req_addr_q;
  assign acc_mask  = (state_q == S_IDLE) ? memory_interface_frame_mask : req_mask_q;
  assign acc_write = (state_q == S_IDLE) ? memory_interface_memory_state : req_write_q;
  assign acc_index = acc_addr[DEPTH_LOG2+1:2];
  assign acc_oor   = |acc_addr[31:DEPTH_LOG2+2];
  assign rd_word   = mem_q[acc_index];

  // Masked read lanes; out-of-range reads return all zeros.
  always_comb begin
    rd_lookup = '0;
    for (int i = 0; i < 4; i++) begin
      if (acc_mask[i] && !acc_oor) begin
        rd_lookup[8*i +: 8] = rd_word[8*i +: 8];
      end
    end
  end

  // Captured request decode, used by the write that ends RESPOND.
  logic [DEPTH_LOG2-1:0] req_index;
  logic                  req_oor;

  assign req_index = req_addr_q[DEPTH_LOG2+1:2];
  assign req_oor   = |req_addr_q[31:DEPTH_LOG2+2];

  // Next-state logic: FSM, wait counter, request capture, read-data capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_mask_d  = req_mask_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (memory_interface_enable) begin
          req_write_d = memory_interface_memory_state;
          req_addr_d  = memory_interface_address[31:2];
          req_mask_d  = memory_interface_frame_mask;
          req_wdata_d = memory_interface_write_data;
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = LAT_LOAD;
          end else begin
            state_d = S_RESPOND;
            if (!acc_write) rdata_d = rd_lookup;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESPOND;
          if (!acc_write) rdata_d = rd_lookup;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and request registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_mask_q  <= 4'd0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_mask_q  <= req_mask_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Storage: masked lanes commit on the edge that ends RESPOND. Contents are
  // never reset; a reset arriving in RESPOND discards the write.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_RESPOND && req_write_q && !req_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (req_mask_q[i]) begin
          mem_q[req_index][8*i +: 8] <= req_wdata_q[8*i +: 8];
        end
      end
    end
  end

  // done/error are suppressed while reset is asserted so an aborted access
  // never shows a completion.
  assign memory_interface_done      = (state_q == S_RESPOND) && !reset;
  assign memory_interface_error     = memory_interface_done && req_oor;
  assign memory_interface_busy      = (state_q != S_IDLE);
  assign memory_interface_read_data = rdata_q;
  assign dbg_state_o                = state_q;

endmodule

// File: tb/tb_memory_interface_responder.sv
// Bench for memory_interface_responder: directed cases with literal
// expectations, randomized accesses against a byte-level memory model with
// a cycle-by-cycle compare of done/busy/error/read_data, and a latency sweep
// on extra instances with enable held high.
module tb_memory_interface_responder;

  localparam int LAT = 2;
  localparam int DL  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        en, st;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;
  logic [31:0] rd;
  logic        done, busy, err;
  logic [1:0]  dbg;

  memory_interface_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk                           (clk),
    .reset                         (reset),
    .memory_interface_enable       (en),
    .memory_interface_memory_state (st),
    .memory_interface_address      (addr),
    .memory_interface_frame_mask   (mask),
    .memory_interface_write_data   (wdata),
    .memory_interface_read_data    (rd),
    .memory_interface_done         (done),
    .memory_interface_busy         (busy),
    .memory_interface_error        (err),
    .dbg_state_o                   (dbg)
  );

  // Latency-sweep instances (LATENCY 0, 1, 15), reads of word 0.
  logic [2:0]  en_l;
  logic [31:0] rd_l   [3];
  logic        done_l [3];
  logic        busy_l [3];
  logic        err_l  [3];
  logic [1:0]  dbg_l  [3];
  int          lat_tab [3] = '{0, 1, 15};

  memory_interface_responder #(.DEPTH_LOG2(DL), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .memory_interface_enable(en_l[0]),
    .memory_interface_memory_state(1'b0), .memory_interface_address(32'd0),
    .memory_interface_frame_mask(4'hF), .memory_interface_write_data(32'd0),
    .memory_interface_read_data(rd_l[0]), .memory_interface_done(done_l[0]),
    .memory_interface_busy(busy_l[0]), .memory_interface_error(err_l[0]),
    .dbg_state_o(dbg_l[0]));
  memory_interface_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .memory_interface_enable(en_l[1]),
    .memory_interface_memory_state(1'b0), .memory_interface_address(32'd0),
    .memory_interface_frame_mask(4'hF), .memory_interface_write_data(32'd0),
    .memory_interface_read_data(rd_l[1]), .memory_interface_done(done_l[1]),
    .memory_interface_busy(busy_l[1]), .memory_interface_error(err_l[1]),
    .dbg_state_o(dbg_l[1]));
  memory_interface_responder #(.DEPTH_LOG2(DL), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .memory_interface_enable(en_l[2]),
    .memory_interface_memory_state(1'b0), .memory_interface_address(32'd0),
    .memory_interface_frame_mask(4'hF), .memory_interface_write_data(32'd0),
    .memory_interface_read_data(rd_l[2]), .memory_interface_done(done_l[2]),
    .memory_interface_busy(busy_l[2]), .memory_interface_error(err_l[2]),
    .dbg_state_o(dbg_l[2]));

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory known byte-by-byte; bytes never written are "don't care".
  logic [7:0]  mem_m [int];
  logic [31:0] last_rd   = 32'd0;
  logic [31:0] last_care = 32'hFFFF_FFFF;
  // Expected responses: {error, care mask, read_data}.
  logic [64:0] exp_q[$];
  bit          have_req    = 1'b0;
  int          acc_cyc     = 0;
  bit          checking_on = 1'b0;

  function automatic void model_accept(input bit wr, input logic [31:0] a,
                                       input logic [3:0] m, input logic [31:0] d);
    bit          oor;
    int          base;
    logic [31:0] data, care;
    logic [DL-1:0] idx;
    oor  = (a[31:DL+2] != '0);
    idx  = a[DL+1:2];
    base = int'(idx) * 4;
    data = 32'd0;
    care = 32'hFFFF_FFFF;
    if (!wr) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i] && !oor) begin
          if (mem_m.exists(base + i)) data[8*i +: 8] = mem_m[base + i];
          else care[8*i +: 8] = 8'h00;
        end
      end
      last_rd   = data;
      last_care = care;
      exp_q.push_back({oor, care, data});
    end else begin
      exp_q.push_back({oor, last_care, last_rd});
      if (!oor) begin
        for (int i = 0; i < 4; i++) begin
          if (m[i]) mem_m[base + i] = d[8*i +: 8];
        end
      end
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic [64:0] e;
    bit          xd, xb;
    if (checking_on) begin
      if (reset) begin
        chk("done_during_reset", {31'd0, done}, 32'd0);
      end else begin
        xd = have_req && (cyc == acc_cyc + LAT + 1);
        xb = have_req && (cyc > acc_cyc) && (cyc <= acc_cyc + LAT + 1);
        chk("done", {31'd0, done}, {31'd0, xd});
        chk("busy", {31'd0, busy}, {31'd0, xb});
        if (xd) begin
          if (exp_q.size() == 0) begin
            chk("response_expected", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("error", {31'd0, err}, {31'd0, e[64]});
            chk("read_data", rd & e[63:32], e[31:0] & e[63:32]);
          end
        end else if (!xb) begin
          chk("error_idle", {31'd0, err}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input bit wr, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] d, output logic [31:0] got_rd,
                           output logic got_err);
    @(negedge clk);
    en = 1'b1; st = wr; addr = a; mask = m; wdata = d;
    model_accept(wr, a, m, d);
    acc_cyc  = cyc;
    have_req = 1'b1;
    @(negedge clk);
    // Enable drops; the remaining inputs wander and must be ignored.
    en = 1'b0; st = 1'($urandom_range(0, 1)); addr = $urandom;
    mask = 4'($urandom_range(0, 15)); wdata = $urandom;
    while (cyc != acc_cyc + LAT + 1) @(negedge clk);
    got_rd  = rd;
    got_err = err;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] r;
  logic        e1;

  initial begin
    reset = 1'b1; en = 1'b0; st = 1'b0; addr = '0; mask = '0; wdata = '0;
    en_l = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_error", {31'd0, err}, 32'd0);
    chk("reset_read_data", rd, 32'd0);
    checking_on = 1'b1;

    // First read after reset: timing only, contents unknown.
    do_access(1'b0, 32'h0000_0100, 4'hF, 32'd0, r, e1);

    // Full word write/read.
    do_access(1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, r, e1);
    do_access(1'b0, 32'h0000_0040, 4'hF, 32'd0, r, e1);
    chk("full_word", r, 32'hDEAD_BEEF);

    // Byte lanes.
    do_access(1'b1, 32'h0000_0042, 4'b0100, 32'h00AA_0000, r, e1);
    do_access(1'b0, 32'h0000_0040, 4'hF, 32'd0, r, e1);
    chk("lane2_write", r, 32'hDEAA_BEEF);
    do_access(1'b0, 32'h0000_0040, 4'b0011, 32'd0, r, e1);
    chk("mask_0011", r, 32'h0000_BEEF);

    // Out of range (aliases word 0 if the range check were missing).
    do_access(1'b1, 32'h0000_0000, 4'hF, 32'h55AA_55AA, r, e1);
    do_access(1'b1, 32'h0000_1000, 4'hF, 32'h1111_1111, r, e1);
    chk("oor_write_error", {31'd0, e1}, 32'd1);
    do_access(1'b0, 32'h0000_1000, 4'hF, 32'd0, r, e1);
    chk("oor_read_error", {31'd0, e1}, 32'd1);
    chk("oor_read_data", r, 32'd0);
    do_access(1'b0, 32'h0000_0000, 4'hF, 32'd0, r, e1);
    chk("oor_no_store", r, 32'h55AA_55AA);
    do_access(1'b0, 32'h0000_0FFC, 4'hF, 32'd0, r, e1);
    chk("last_word_error", {31'd0, e1}, 32'd0);

    // Empty mask.
    do_access(1'b1, 32'h0000_0040, 4'h0, 32'hFFFF_FFFF, r, e1);
    do_access(1'b0, 32'h0000_0040, 4'h0, 32'd0, r, e1);
    chk("mask0_read", r, 32'd0);
    do_access(1'b0, 32'h0000_0040, 4'hF, 32'd0, r, e1);
    chk("mask0_no_write", r, 32'hDEAA_BEEF);

    // Reset during WAIT discards the write and clears read_data.
    do_access(1'b1, 32'h0000_0080, 4'hF, 32'hCAFE_F00D, r, e1);
    @(negedge clk);
    en = 1'b1; st = 1'b1; addr = 32'h0000_0080; mask = 4'hF; wdata = 32'h1234_5678;
    acc_cyc = cyc; have_req = 1'b1;
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1; have_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_rd = 32'd0; last_care = 32'hFFFF_FFFF;
    chk("midop_reset_busy", {31'd0, busy}, 32'd0);
    chk("midop_reset_read_data", rd, 32'd0);
    do_access(1'b0, 32'h0000_0080, 4'hF, 32'd0, r, e1);
    chk("midop_write_discarded", r, 32'hCAFE_F00D);

    // Randomized traffic over a small window of words.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1048575)) << 12);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, r, e1);
    end

    // Latency sweep: enable held high, done every L+2 cycles from acc+L+1.
    @(negedge clk);
    begin
      int c0;
      int rel;
      int p;
      c0   = cyc;
      en_l = 3'b111;
      for (int n = 0; n < 60; n++) begin
        @(negedge clk);
        rel = cyc - c0;
        for (int k = 0; k < 3; k++) begin
          p = rel % (lat_tab[k] + 2);
          chk($sformatf("sweep_done_L%0d", lat_tab[k]), {31'd0, done_l[k]},
              {31'd0, p == lat_tab[k] + 1});
          chk($sformatf("sweep_busy_L%0d", lat_tab[k]), {31'd0, busy_l[k]},
              {31'd0, p != 0});
        end
      end
      en_l = 3'b000;
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) chk("leftover_responses", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run is bounded in cycles by construction; this catches hangs.
  initial begin
    #400000;
    $display("FAIL watchdog: timeout at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
